// File: rtl/bloco_pkg.sv
// Shared encodings for the bloco_operativo datapath and its controller.
package bloco_pkg;

    // X register input select.
    typedef enum logic [1:0] {
        SEL_X_ENTRADA = 2'b00,
        SEL_X_ULA     = 2'b01,
        SEL_X_S       = 2'b10,
        SEL_X_ZERO    = 2'b11
    } sel_x_t;

    // ALU operand A select.
    typedef enum logic [1:0] {
        SEL_A_X  = 2'b00,
        SEL_A_HR = 2'b01,
        SEL_A_S  = 2'b10,
        SEL_A_UM = 2'b11
    } sel_a_t;

    // ALU operand B select.
    typedef enum logic [1:0] {
        SEL_B_X       = 2'b00,
        SEL_B_HR      = 2'b01,
        SEL_B_ENTRADA = 2'b10,
        SEL_B_ZERO    = 2'b11
    } sel_b_t;

    // ALU operation.
    typedef enum logic {
        ULA_SOMA = 1'b0,
        ULA_SUB  = 1'b1
    } ula_op_t;

endpackage

// File: rtl/bloco_operativo_ula.sv
// Add/subtract ALU; c is the carry out for a sum and the borrow for a difference.
module ula
    import bloco_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  ula_op_t          op,
    output logic [WIDTH-1:0] r,
    output logic             c
);

    logic [WIDTH:0] w_full;

    // Widen by one bit so the top bit is carry (sum) or borrow (a < b on subtract).
    always_comb begin
        if (op == ULA_SUB) begin
            w_full = {1'b0, a} - {1'b0, b};
        end else begin
            w_full = {1'b0, a} + {1'b0, b};
        end
    end

    assign r = w_full[WIDTH-1:0];
    assign c = w_full[WIDTH];

endmodule

// File: rtl/bloco_operativo.sv
// Datapath stage: X/HR/S working registers, ALU, sticky overflow and
// edge-triggered result capture, all steered by blocoControle.
module bloco_operativo
    import bloco_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       M0,
    input  logic [1:0]       M1,
    input  logic [1:0]       M2,
    input  logic             LX,
    input  logic             LH,
    input  logic             LS,
    input  logic             H,
    input  logic             pronto,
    input  logic [WIDTH-1:0] entrada_a,
    input  logic [WIDTH-1:0] entrada_b,
    output logic [WIDTH-1:0] saida,
    output logic             saida_valida,
    output logic             zero,
    output logic             overflow
);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_hr;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_saida;
    logic             r_saida_valida;
    logic             r_overflow;
    logic             r_pronto_q;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_x_next;
    logic [WIDTH-1:0] w_r;
    logic             w_c;
    logic             w_pronto_rise;
    logic             w_ovf_set;
    logic             w_ovf_clr;

    // Operand and X-input multiplexers.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_a      = '0;
        w_b      = '0;
        w_x_next = '0;

        case (sel_a_t'(M1))
            SEL_A_X:  w_a = r_x;
            SEL_A_HR: w_a = r_hr;
            SEL_A_S:  w_a = r_s;
            SEL_A_UM: w_a = WIDTH'(1);
        endcase

        case (sel_b_t'(M2))
            SEL_B_X:       w_b = r_x;
            SEL_B_HR:      w_b = r_hr;
            SEL_B_ENTRADA: w_b = entrada_b;
            SEL_B_ZERO:    w_b = '0;
        endcase

        case (sel_x_t'(M0))
            SEL_X_ENTRADA: w_x_next = entrada_a;
            SEL_X_ULA:     w_x_next = w_r;
            SEL_X_S:       w_x_next = r_s;
            SEL_X_ZERO:    w_x_next = '0;
        endcase
    end

    ula #(.WIDTH(WIDTH)) u_ula (
        .a  (w_a),
        .b  (w_b),
        .op (ula_op_t'(H)),
        .r  (w_r),
        .c  (w_c)
    );

    assign w_pronto_rise = pronto & ~r_pronto_q;
    assign w_ovf_set     = (LH | LS) & w_c;
    assign w_ovf_clr     = LX & (sel_x_t'(M0) == SEL_X_ENTRADA);

    // Working registers; each loads from the same pre-edge ALU result.
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x  <= '0;
            r_hr <= '0;
            r_s  <= '0;
        end else begin
            if (LX) r_x  <= w_x_next;
            if (LH) r_hr <= w_r;
            if (LS) r_s  <= w_r;
        end
    end

    // Sticky overflow: set by a carry/borrow on an HR/S load, cleared by a new operand load; set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Capture S on a rising pronto and emit a single-cycle valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pronto_q     <= 1'b0;
            r_saida        <= '0;
            r_saida_valida <= 1'b0;
        end else begin
            r_pronto_q     <= pronto;
            r_saida_valida <= w_pronto_rise;
            if (w_pronto_rise) r_saida <= r_s;
        end
    end

    assign saida        = r_saida;
    assign saida_valida = r_saida_valida;
    assign overflow     = r_overflow;
    assign zero         = (r_s == '0);

endmodule

// File: tb/tb_bloco_operativo.sv
// Self-checking bench for bloco_operativo (WIDTH=8): directed scenarios plus
// random control traffic, compared against an arithmetic reference model.
module tb_bloco_operativo;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [1:0]   M0, M1, M2;
    logic         LX, LH, LS, H, pronto;
    logic [W-1:0] entrada_a, entrada_b;
    logic [W-1:0] saida;
    logic         saida_valida, zero, overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int mx, mh, ms, msaida, mval, movf, mpq;

    bloco_operativo #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .M0           (M0),
        .M1           (M1),
        .M2           (M2),
        .LX           (LX),
        .LH           (LH),
        .LS           (LS),
        .H            (H),
        .pronto       (pronto),
        .entrada_a    (entrada_a),
        .entrada_b    (entrada_b),
        .saida        (saida),
        .saida_valida (saida_valida),
        .zero         (zero),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; mh = 0; ms = 0; msaida = 0; mval = 0; movf = 0; mpq = 0;
    endtask

    // One clock edge of the datapath, in plain arithmetic.
    task automatic model_edge();
        int a, b, res, r, cy, nx;
        int opa[4];
        int opb[4];
        opa = '{mx, mh, ms, 1};
        opb = '{mx, mh, int'(entrada_b), 0};
        a = opa[M1];
        b = opb[M2];
        if (H) begin
            res = a - b;
            cy  = (a < b) ? 1 : 0;
        end else begin
            res = a + b;
            cy  = (res > 255) ? 1 : 0;
        end
        r = res & 255;
        case (M0)
            2'd0:    nx = int'(entrada_a);
            2'd1:    nx = r;
            2'd2:    nx = ms;
            default: nx = 0;
        endcase
        if ((LH || LS) && cy == 1)        movf = 1;
        else if (LX && M0 == 2'd0)        movf = 0;
        if (pronto && mpq == 0) begin
            msaida = ms;
            mval   = 1;
        end else begin
            mval = 0;
        end
        mpq = pronto ? 1 : 0;
        if (LX) mx = nx;
        if (LH) mh = r;
        if (LS) ms = r;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".saida"},    32'(saida),        32'(msaida));
        check({tag, ".valida"},   32'(saida_valida), 32'(mval));
        check({tag, ".overflow"}, 32'(overflow),     32'(movf));
        check({tag, ".zero"},     32'(zero),         (ms == 0) ? 32'd1 : 32'd0);
    endtask

    // Advance one clock with the current inputs and compare against the model.
    task automatic tick(input string tag);
        if (rst) model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        M0 = 2'd0; M1 = 2'd0; M2 = 2'd0;
        LX = 1'b0; LH = 1'b0; LS = 1'b0; H = 1'b0; pronto = 1'b0;
        entrada_a = '0; entrada_b = '0;
    endtask

    // Pulse pronto for one cycle, then let saida show up.
    task automatic pulse(input string tag, input int exp_saida);
        idle();
        pronto = 1'b1;
        tick({tag, ".rise"});
        check({tag, ".saida_cte"}, 32'(saida), 32'(exp_saida));
        check({tag, ".valida_cte"}, 32'(saida_valida), 32'd1);
        pronto = 1'b0;
        tick({tag, ".fall"});
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b0;
        #12;
        check_all("reset_async");
        rst = 1'b1;

        // 1. Idle after reset.
        tick("t1");
        tick("t1");
        check("t1.saida", 32'(saida), 32'd0);
        check("t1.zero", 32'(zero), 32'd1);
        check("t1.ovf", 32'(overflow), 32'd0);

        // 2. X=5, S=X+3=8, pronto held 3 cycles -> one pulse.
        idle(); LX = 1'b1; M0 = 2'd0; entrada_a = 8'd5;
        tick("t2.ldx");
        idle(); M1 = 2'd0; M2 = 2'd2; entrada_b = 8'd3; LS = 1'b1;
        tick("t2.lds");
        check("t2.zero", 32'(zero), 32'd0);
        idle(); pronto = 1'b1;
        tick("t2.p1");
        check("t2.saida", 32'(saida), 32'd8);
        check("t2.val1", 32'(saida_valida), 32'd1);
        tick("t2.p2");
        check("t2.val2", 32'(saida_valida), 32'd0);
        tick("t2.p3");
        check("t2.val3", 32'(saida_valida), 32'd0);
        idle();
        tick("t2.end");

        // 3. HR = 200+100 = 44 with carry; overflow sticky.
        idle(); LX = 1'b1; M0 = 2'd0; entrada_a = 8'd200;
        tick("t3.ldx");
        idle(); M2 = 2'd2; entrada_b = 8'd100; LH = 1'b1;
        tick("t3.ldh");
        check("t3.ovf_set", 32'(overflow), 32'd1);
        idle(); M1 = 2'd1; M2 = 2'd3; LS = 1'b1;      // S = HR + 0, no carry
        tick("t3.hr2s");
        check("t3.ovf_hold", 32'(overflow), 32'd1);
        pulse("t3.hr", 44);
        idle(); LX = 1'b1; M0 = 2'd1; M1 = 2'd3; M2 = 2'd3;  // X = 1 via ALU, no clear
        tick("t3.x_ula");
        check("t3.ovf_hold2", 32'(overflow), 32'd1);
        idle(); LX = 1'b1; M0 = 2'd0; entrada_a = 8'd3;
        tick("t3.clr");
        check("t3.ovf_clr", 32'(overflow), 32'd0);

        // 4. S = 3-7 = 252 with borrow; then S = 7-0, overflow stays.
        idle(); M2 = 2'd2; entrada_b = 8'd7; H = 1'b1; LS = 1'b1;
        tick("t4.sub");
        check("t4.ovf", 32'(overflow), 32'd1);
        pulse("t4.s", 252);
        idle(); LX = 1'b1; M0 = 2'd1; M1 = 2'd3; M2 = 2'd2; entrada_b = 8'd6;  // X = 1+6
        tick("t4.x7");
        idle(); M2 = 2'd3; H = 1'b1; LS = 1'b1;
        tick("t4.sub0");
        check("t4.ovf_keep", 32'(overflow), 32'd1);
        pulse("t4.s7", 7);

        // 5. Capture uses pre-edge S even when S loads on the same edge.
        idle(); LX = 1'b1; M0 = 2'd0; entrada_a = 8'd10;
        tick("t5.ldx");
        idle(); M2 = 2'd3; LS = 1'b1;
        tick("t5.s10");
        idle(); M2 = 2'd0; LS = 1'b1; pronto = 1'b1;   // S <= X+X = 20
        tick("t5.both");
        check("t5.saida", 32'(saida), 32'd10);
        idle();
        tick("t5.gap");
        pulse("t5.s20", 20);

        // 6. Counter HR = HR + 1 for 256 cycles wraps to 0 with carry.
        idle(); LX = 1'b1; M0 = 2'd0; entrada_a = 8'd0; LH = 1'b1; M1 = 2'd0; M2 = 2'd0; H = 1'b1;
        tick("t6.init");
        idle(); M1 = 2'd3; M2 = 2'd1; LH = 1'b1;
        for (int i = 0; i < 255; i++) tick("t6.cnt");
        check("t6.ovf_pre", 32'(overflow), 32'd0);
        tick("t6.wrap");
        check("t6.ovf_wrap", 32'(overflow), 32'd1);
        idle(); M1 = 2'd1; M2 = 2'd3; LS = 1'b1;
        tick("t6.hr2s");
        check("t6.hr_zero", 32'(zero), 32'd1);
        idle(); LX = 1'b1; M0 = 2'd0; entrada_a = 8'd9; LS = 1'b1; M1 = 2'd3; M2 = 2'd3;
        tick("t6.s1");
        idle(); M1 = 2'd3; M2 = 2'd1; LH = 1'b1; pronto = 1'b1;
        for (int i = 0; i < 100; i++) tick("t6.cnt2");
        rst = 1'b0;
        #2;
        model_reset();
        check_all("t6.rst_mid");
        check("t6.rst_zero", 32'(zero), 32'd1);
        idle();
        tick("t6.inrst");
        rst = 1'b1;
        tick("t6.rel");
        pulse("t6.after", 0);

        // Random control traffic against the model.
        for (int i = 0; i < 400; i++) begin
            M0 = 2'($urandom_range(0, 3));
            M1 = 2'($urandom_range(0, 3));
            M2 = 2'($urandom_range(0, 3));
            LX = 1'($urandom);
            LH = 1'($urandom);
            LS = 1'($urandom);
            H  = 1'($urandom);
            pronto = ($urandom_range(0, 3) != 0);
            entrada_a = 8'($urandom);
            entrada_b = 8'($urandom);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bloco_operativo.md
Name: bloco_operativo

Overview:
Datapath stage driven directly by blocoControle. It consumes the mux selects M0/M1/M2, the load enables LX/LH/LS, the ALU operation select H and the pronto strobe, and holds the three working registers X, HR and S. On a pronto rising edge it captures the final result and presents it downstream with a one-cycle valid pulse. It also returns status flags (zero, overflow) that blocoControle can use for branching.

Parameters:
WIDTH, 8, datapath width in bits for inputs, registers, ALU and result.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
M0  input  2  X-register input mux select.
M1  input  2  ALU operand A mux select.
M2  input  2  ALU operand B mux select.
LX  input  1  load enable for X.
LH  input  1  load enable for HR.
LS  input  1  load enable for S.
H  input  1  ALU operation: 0 = A+B, 1 = A-B.
pronto  input  1  done strobe from control.
entrada_a  input  WIDTH  external operand A.
entrada_b  input  WIDTH  external operand B.
saida  output  WIDTH  registered result.
saida_valida  output  1  one-cycle pulse when saida is updated.
zero  output  1  combinational flag, S == 0.
overflow  output  1  sticky carry/borrow flag.

Behaviour:
- Reset (rst=0, asynchronous): X, HR, S, saida = 0; saida_valida = 0; overflow = 0; pronto_q = 0. zero therefore reads 1.
- M0 mux, next X value: 00 = entrada_a, 01 = ALU result, 10 = S, 11 = 0.
- M1 mux, operand A: 00 = X, 01 = HR, 10 = S, 11 = constant 1.
- M2 mux, operand B: 00 = X, 01 = HR, 10 = entrada_b, 11 = constant 0.
- ALU is combinational and computes WIDTH+1 bits:
  - H=0: {c, r} = A + B.
  - H=1: {c, r} = A - B, where c = borrow (A < B unsigned).
  - The result r is truncated mod 2^WIDTH.
- Register loads:
  - LX=1: X <= M0 mux output.
  - LH=1: HR <= r.
  - LS=1: S <= r.
  - Any combination may be asserted in the same cycle; all registers load from the same pre-edge ALU result.
  - A register whose enable is low holds its value.
- overflow:
  - Set on any edge where (LH or LS) and c = 1.
  - Cleared on any edge where LX=1 and M0=00 (new operand load).
  - If set and clear occur in the same cycle, set wins.
- Result capture:
  - pronto_q is pronto delayed one cycle.
  - On an edge with pronto=1 and pronto_q=0: saida <= S (the pre-edge value, even if LS=1 that cycle) and saida_valida <= 1.
  - Otherwise saida_valida <= 0.
  - Holding pronto high yields exactly one pulse; a new pulse needs pronto to drop low for at least one cycle.
- Latency:
  - Register updates are 1 cycle after the control signals.
  - saida/saida_valida appear 1 cycle after pronto rises.
- zero is combinational from S only; it reflects the current S with no extra latency.
- Reset asserted mid-operation clears all state immediately. After release, the first pronto rise outputs 0.
- No internal FSM sequencing: control ordering is owned entirely by blocoControle. This block never stalls.

Decomposition:
- Shared package (bloco_pkg):
  - Select encodings SEL_X_ENTRADA/SEL_X_ULA/SEL_X_S/SEL_X_ZERO.
  - SEL_A_X/SEL_A_HR/SEL_A_S/SEL_A_UM.
  - SEL_B_X/SEL_B_HR/SEL_B_ENTRADA/SEL_B_ZERO.
  - ULA_SOMA=0, ULA_SUB=1.
  - Shared with blocoControle so the encodings have a single definition.
- One sub-module: ula (parameterised WIDTH; inputs a, b, op; outputs r, c).
- Muxes and registers stay in bloco_operativo.

Test Plan (WIDTH=8):
1. Reset then release; hold pronto=0 -> saida=0, saida_valida=0, overflow=0, zero=1.
2. entrada_a=5 with LX=1, M0=00; next cycle M1=00, M2=10, entrada_b=3, H=0, LS=1; then pronto=1 held for 3 cycles -> S=8, zero=0, saida=8, saida_valida high for exactly 1 cycle.
3. X=200, entrada_b=100, H=0, LH=1 -> HR=44, overflow=1; it stays 1 across later no-carry loads until LX=1 with M0=00.
4. X=3, M2=10, entrada_b=7, H=1, LS=1 -> S=252, overflow=1. Then X=7, M2=11 (B=0), H=1, LS=1 -> S=7, overflow stays 1.
5. S=10; in one cycle assert LS=1 with ALU result 20 and pronto rising -> saida=10, S=20 afterwards.
6. Counter loop: M1=11, M2=01, H=0, LH=1 for 256 cycles starting from HR=0 -> HR wraps to 0, overflow set on the wrap. Assert rst low mid-loop -> all registers 0 immediately.
